// File: rtl/csa_resolve_if.sv
// Handshake bundle for the carry-save resolver.
// The upstream side presents a sum/carry pair. The downstream side takes the
// resolved binary result. The master modport is the environment and the
// slave modport is the resolver.
interface csa_resolve_if #(
    parameter int WIDTH = 32
);
    localparam int IW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic             out_ovf;
    logic [IW-1:0]    out_iters;

    modport master (
        output in_valid, in_s, in_c, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, out_iters
    );

    modport slave (
        input  in_valid, in_s, in_c, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, out_iters
    );
endinterface

// File: rtl/csa_resolve.sv
// Carry-save resolver.
// The block accepts a redundant sum/carry pair and reduces it to a binary
// value. Each clock performs one compression step: the sum becomes S^C and
// the carry becomes (S&C)<<1. The block stops when the carry reaches zero.
// A carry bit that is shifted out of bit WIDTH sets the overflow flag.
// The optional macro CSA_RESOLVE_SHORTCUT_EN skips the compression phase
// when the input carry is zero.
module csa_resolve #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    csa_resolve_if.slave    bus
);
    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [WIDTH:0] s_reg, s_next;
    logic [WIDTH:0] c_reg, c_next;
    logic           ovf_reg, ovf_next;
    logic [IW-1:0]  iter_reg, iter_next;

    logic [WIDTH:0] s_step;
    logic [WIDTH:0] sc_and;
    logic [WIDTH:0] c_step;
    logic           accept;

    // Per-bit compression terms: a half-adder in every bit position.
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_bit
            assign s_step[gi] = s_reg[gi] ^ c_reg[gi];
            assign sc_and[gi] = s_reg[gi] & c_reg[gi];
        end
    endgenerate

    // The carry moves up one weight. The bit that leaves the top feeds OVF.
    assign c_step = {sc_and[WIDTH-1:0], 1'b0};

    assign bus.in_ready  = rst_n && (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_sum   = s_reg;
    assign bus.out_ovf   = ovf_reg;
    assign bus.out_iters = iter_reg;

    assign accept = bus.in_valid && bus.in_ready;

    // State and datapath registers. Reset discards any job in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            c_reg     <= '0;
            ovf_reg   <= 1'b0;
            iter_reg  <= '0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            c_reg     <= c_next;
            ovf_reg   <= ovf_next;
            iter_reg  <= iter_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        c_next     = c_reg;
        ovf_next   = ovf_reg;
        iter_next  = iter_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    s_next     = {1'b0, bus.in_s};
                    c_next     = {bus.in_c, 1'b0};
                    ovf_next   = 1'b0;
                    iter_next  = '0;
                    state_next = RUN;
`ifdef CSA_RESOLVE_SHORTCUT_EN
                    // A zero carry is already resolved, so no step is needed.
                    if (bus.in_c == '0) begin
                        state_next = DONE;
                    end
`endif
                end
            end
            RUN: begin
                s_next    = s_step;
                c_next    = c_step;
                ovf_next  = ovf_reg | sc_and[WIDTH];
                iter_next = iter_reg + {{(IW-1){1'b0}}, 1'b1};
                if (c_step == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_csa_resolve.sv
// Directed bench for csa_resolve. The expected values are computed by hand.
module tb_csa_resolve;
    localparam int WIDTH = 32;
    localparam int IW    = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    csa_resolve_if #(.WIDTH(WIDTH)) bus ();

    csa_resolve #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one pair, then return right after its acceptance edge.
    task automatic send(input string tag, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.in_s     = s;
        bus.in_c     = c;
        step();
        bus.in_valid = 1'b0;
        check({tag, "_busy"}, {63'd0, bus.in_ready}, 64'd0);
    endtask

    // Wait for out_valid and return the number of edges counted after acceptance.
    task automatic wait_valid(input string tag, output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
        end
        check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    endtask

    task automatic run_job(input string tag, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                           input logic [WIDTH:0] esum, input logic eovf, input int eiters, input int elat);
        int lat;
        send(tag, s, c);
        wait_valid(tag, lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_sum"}, 64'(bus.out_sum), 64'(esum));
        check({tag, "_ovf"}, {63'd0, bus.out_ovf}, {63'd0, eovf});
        check({tag, "_iters"}, 64'(bus.out_iters), 64'(eiters));
        $display("job %s s=0x%08h c=0x%08h sum=0x%09h ovf=%0d iters=%0d lat=%0d",
                 tag, s, c, bus.out_sum, bus.out_ovf, bus.out_iters, lat);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_released"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_idle"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        int lat;
        int zi;
        int zl;
        logic [WIDTH:0] held;
`ifdef CSA_RESOLVE_SHORTCUT_EN
        zi = 0;
        zl = 0;
`else
        zi = 1;
        zl = 1;
`endif
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_sum", 64'(bus.out_sum), 64'd0);
        check("rst_ovf", {63'd0, bus.out_ovf}, 64'd0);
        check("rst_iters", 64'(bus.out_iters), 64'd0);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst_n = 1'b1;
        step();

        // Main function
        run_job("t5_8", 32'd5, 32'd8, 33'd21, 1'b0, 1, 1);
        run_job("ripple", 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0001, 1'b0, 32, 32);
        run_job("ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_FFFF_FFFD, 1'b1, 2, 2);
        run_job("zero_c", 32'd7, 32'd0, 33'd7, 1'b0, zi, zl);
        run_job("zero_all", 32'd0, 32'd0, 33'd0, 1'b0, zi, zl);

        // Back-pressure: hold in DONE and ignore new input.
        send("hold", 32'd5, 32'd8);
        wait_valid("hold", lat);
        held = bus.out_sum;
        check("hold_sum0", 64'(held), 64'd21);
        bus.in_valid = 1'b1;
        bus.in_s     = 32'd100;
        bus.in_c     = 32'd100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
            check("hold_sum", 64'(bus.out_sum), 64'(held));
            check("hold_iters", 64'(bus.out_iters), 64'd1);
            check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            $display("hold cycle %0d sum=0x%09h in_ready=%0d", i, bus.out_sum, bus.in_ready);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("hold_release", {63'd0, bus.out_valid}, 64'd0);
        run_job("after_hold", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_FFFF_FFFD, 1'b1, 2, 2);

        // out_ready already high: the handshake completes in the first DONE cycle.
        bus.out_ready = 1'b1;
        send("rdy_hi", 32'd5, 32'd8);
        check("rdy_hi_valid", {63'd0, bus.out_valid}, 64'd0);
        step();
        check("rdy_hi_done", {63'd0, bus.out_valid}, 64'd1);
        check("rdy_hi_sum", 64'(bus.out_sum), 64'd21);
        step();
        check("rdy_hi_gone", {63'd0, bus.out_valid}, 64'd0);
        check("rdy_hi_idle", {63'd0, bus.in_ready}, 64'd1);
        $display("job rdy_hi sum=21 completed with out_ready held high");
        bus.out_ready = 1'b0;

        // Reset while the worst-case job is running
        send("rst_run", 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        step();
        check("rr_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rr_sum", 64'(bus.out_sum), 64'd0);
        check("rr_ovf", {63'd0, bus.out_ovf}, 64'd0);
        check("rr_iters", 64'(bus.out_iters), 64'd0);
        check("rr_in_ready", {63'd0, bus.in_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rr_idle", {63'd0, bus.in_ready}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            step();
            check("rr_no_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        $display("reset during run: job discarded");
        run_job("post_rst", 32'd5, 32'd8, 33'd21, 1'b0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
